// File: rtl/layer_stream_packer_pkg.sv
// Shared definitions for the inter-layer stream packer: FSM encoding,
// default sizes and a width helper.
package layer_stream_packer_pkg;

  // dataWidth and numNeuronLayerN of the producing network
  localparam int DATA_WIDTH_DEF = 16;
  localparam int NUM_WORDS_DEF  = 30;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  // Bits needed to index 'value' items, never less than one.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if (int'(32'd1 << i) < value) begin
        width = i + 1;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/layer_stream_packer_gap_timer.sv
// Saturating idle-cycle counter; pulses o_timeout on the idle cycle that
// brings the count to GAP_TIMEOUT. GAP_TIMEOUT of zero disables the pulse.
module layer_stream_packer_gap_timer
  import layer_stream_packer_pkg::*;
#(
  parameter int GAP_TIMEOUT = 64
) (
  input  logic aclk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int              GW      = clog2(GAP_TIMEOUT + 1);
  localparam logic [GW-1:0]   LIM     = GW'(GAP_TIMEOUT);
  localparam logic [GW-1:0]   TMO_AT  = GW'(GAP_TIMEOUT - 1);
  localparam bit              ENABLED = (GAP_TIMEOUT != 32'sd0);

  logic [GW-1:0] r_cnt;

  // idle-cycle counter, cleared by the owner and held at the limit
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + GW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_timeout = ENABLED && i_en && (r_cnt == TMO_AT);

endmodule

// File: rtl/layer_stream_packer.sv
// Serial-to-parallel receiver: gathers NUM_WORDS stream words into one packed
// frame with a valid/ready handoff, flagging stalled partial frames and overflow.
module layer_stream_packer
  import layer_stream_packer_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int NUM_WORDS   = NUM_WORDS_DEF,
  parameter int GAP_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                            aclk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            err_clr,
  output logic                            frame_err,
  output logic                            ovf_err,
  output logic [CNT_WIDTH-1:0]            frame_cnt
);

  localparam int               IDX_W    = clog2(NUM_WORDS);
  localparam int               FW       = NUM_WORDS * DATA_WIDTH;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [FW-1:0]        r_coll, w_frame, r_out_data;
  logic                 r_out_valid, r_frame_err, r_ovf_err;
  logic [CNT_WIDTH-1:0] r_frame_cnt;
  logic                 w_in_ready, w_in_collect, w_acc, w_free, w_complete;
  logic                 w_load_new, w_full_load, w_handoff, w_timeout;

  assign w_acc       = in_valid & w_in_ready;
  assign w_free      = ~r_out_valid | out_ready;
  assign w_complete  = w_acc & (r_idx == IDX_LAST);
  assign w_load_new  = w_complete & w_free;
  assign w_handoff   = r_out_valid & out_ready;
  assign w_full_load = (r_state == ST_FULL) & w_handoff;

  layer_stream_packer_gap_timer #(.GAP_TIMEOUT(GAP_TIMEOUT)) u_gap_timer (
    .aclk      (aclk),
    .reset     (reset),
    .i_clr     (~w_in_collect | w_acc),
    .i_en      (w_in_collect & ~w_acc),
    .o_timeout (w_timeout)
  );

  // state register
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_complete)  w_state_nxt = w_free ? ST_IDLE : ST_FULL;
        else if (w_acc)  w_state_nxt = ST_COLLECT;
        else             w_state_nxt = ST_IDLE;
      end
      ST_COLLECT: begin
        if (w_complete)     w_state_nxt = w_free ? ST_IDLE : ST_FULL;
        else if (w_timeout) w_state_nxt = ST_IDLE;
        else                w_state_nxt = ST_COLLECT;
      end
      ST_FULL: begin
        if (w_handoff) w_state_nxt = ST_IDLE;
        else           w_state_nxt = ST_FULL;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // state-decoded controls
  always_comb begin
    w_in_ready   = 1'b1;
    w_in_collect = 1'b0;
    case (r_state)
      ST_IDLE:    begin w_in_ready = 1'b1; w_in_collect = 1'b0; end
      ST_COLLECT: begin w_in_ready = 1'b1; w_in_collect = 1'b1; end
      ST_FULL:    begin w_in_ready = 1'b0; w_in_collect = 1'b0; end
      default:    begin w_in_ready = 1'b1; w_in_collect = 1'b0; end
    endcase
  end

  // collector with the incoming word merged into its slot
  always_comb begin
    w_frame = r_coll;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (w_acc && (r_idx == IDX_W'(i))) w_frame[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
      else                               w_frame[i*DATA_WIDTH +: DATA_WIDTH] = r_coll[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // collector and slot index; slots are overwritten, never cleared
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_coll <= '0;
      r_idx  <= '0;
    end else begin
      r_coll <= w_frame;
      if (w_complete)                   r_idx <= '0;
      else if (w_acc)                   r_idx <= r_idx + IDX_W'(1);
      else if (w_timeout & w_in_collect) r_idx <= '0;
      else                              r_idx <= r_idx;
    end
  end

  // output frame register and handshake
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_load_new)       r_out_data <= w_frame;
      else if (w_full_load) r_out_data <= r_coll;
      else                  r_out_data <= r_out_data;
      if (w_load_new | w_full_load) r_out_valid <= 1'b1;
      else if (out_ready)           r_out_valid <= 1'b0;
      else                          r_out_valid <= r_out_valid;
      r_frame_cnt <= r_frame_cnt + {{(CNT_WIDTH-1){1'b0}}, w_handoff};
    end
  end

  // sticky error flags; a set event beats a simultaneous clear
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_frame_err <= 1'b0;
      r_ovf_err   <= 1'b0;
    end else begin
      if (w_timeout & w_in_collect) r_frame_err <= 1'b1;
      else if (err_clr)             r_frame_err <= 1'b0;
      else                          r_frame_err <= r_frame_err;
      if ((r_state == ST_FULL) & in_valid) r_ovf_err <= 1'b1;
      else if (err_clr)                    r_ovf_err <= 1'b0;
      else                                 r_ovf_err <= r_ovf_err;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;
  assign ovf_err   = r_ovf_err;
  assign frame_cnt = r_frame_cnt;

endmodule
